// File: rtl/alink_rx_lane_if.sv
// alink_rx_lane_if: word handshake from an ALINK RX lane to its consumer (rxc)
interface alink_rx_lane_if;
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_dat;
   logic        out_last;
   modport master (output out_vld, out_dat, out_last, input out_rdy);
   modport slave  (input out_vld, out_dat, out_last, output out_rdy);
endinterface

// File: rtl/alink_rx_lane.sv
// alink_rx_lane: single-lane ALINK receiver; decodes pulse-per-bit RX_P/RX_N coding
// into 32-bit words with glitch filtering, gap timeout and a 1-entry output buffer.
module alink_rx_lane #(
   parameter int MIN_PULSE   = 4,
   parameter int GAP_TOUT    = 1024,
   parameter int FRAME_WORDS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             rx_p,
   input  logic             rx_n,
   alink_rx_lane_if.master  link,
   output logic             err_pulse,
   output logic             tout_pulse,
   output logic             ovf_pulse,
   output logic             busy
);
   localparam int PW = $clog2(MIN_PULSE + 1);
   localparam int GW = $clog2(GAP_TOUT + 1);
   localparam int WW = $clog2(FRAME_WORDS + 1);
   localparam logic [PW-1:0] MINP  = PW'(MIN_PULSE);
   localparam logic [GW-1:0] GLAST = GW'(GAP_TOUT - 1);
   localparam logic [WW-1:0] WLAST = WW'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {IDLE, PULSE, ERR} state_t;

   state_t        state;
   logic          p1, n1, p_s, n_s;
   logic          bit_val;
   logic [PW-1:0] pulse_cnt;
   logic [5:0]    bit_cnt;
   logic [WW-1:0] word_idx;
   logic [GW-1:0] gap_cnt;
   logic [31:0]   shreg;
   logic          act_low, oth_low, take, done, last_w, room;
   logic [31:0]   word;

   assign act_low = bit_val ? !p_s : !n_s;
   assign oth_low = bit_val ? !n_s : !p_s;
   assign word    = {shreg[30:0], bit_val};
   // a bit is accepted when its pulse ends having been long enough
   assign take    = state == PULSE && !act_low && pulse_cnt >= MINP;
   assign done    = take && bit_cnt == 6'd31;
   assign last_w  = word_idx == WLAST;
   assign room    = !link.out_vld || link.out_rdy;
   assign busy    = bit_cnt != '0 || word_idx != '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1            <= 1'b1;
         n1            <= 1'b1;
         p_s           <= 1'b1;
         n_s           <= 1'b1;
         state         <= IDLE;
         bit_val       <= 1'b0;
         pulse_cnt     <= '0;
         bit_cnt       <= '0;
         word_idx      <= '0;
         gap_cnt       <= '0;
         shreg         <= '0;
         link.out_vld  <= 1'b0;
         link.out_dat  <= '0;
         link.out_last <= 1'b0;
         err_pulse     <= 1'b0;
         tout_pulse    <= 1'b0;
         ovf_pulse     <= 1'b0;
      end else begin
         p1         <= rx_p;
         p_s        <= p1;
         n1         <= rx_n;
         n_s        <= n1;
         err_pulse  <= 1'b0;
         tout_pulse <= 1'b0;
         ovf_pulse  <= 1'b0;
         if (link.out_vld && link.out_rdy) link.out_vld <= 1'b0;
         if (!en) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            word_idx  <= '0;
            gap_cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (!p_s && !n_s) begin
                     state     <= ERR;
                     err_pulse <= 1'b1;
                     bit_cnt   <= '0;
                     word_idx  <= '0;
                     gap_cnt   <= '0;
                  end else if (!p_s || !n_s) begin
                     state     <= PULSE;
                     bit_val   <= !p_s;
                     pulse_cnt <= PW'(1);
                     gap_cnt   <= '0;
                  end else if (busy && gap_cnt == GLAST) begin
                     tout_pulse <= 1'b1;
                     bit_cnt    <= '0;
                     word_idx   <= '0;
                     gap_cnt    <= '0;
                  end else begin
                     gap_cnt <= busy ? gap_cnt + GW'(1) : '0;
                  end
               end
               PULSE: begin
                  if (act_low && oth_low) begin
                     state     <= ERR;
                     err_pulse <= 1'b1;
                     bit_cnt   <= '0;
                     word_idx  <= '0;
                  end else if (act_low) begin
                     pulse_cnt <= pulse_cnt == MINP ? pulse_cnt : pulse_cnt + PW'(1);
                  end else begin
                     state <= IDLE;
                     if (take) begin
                        shreg   <= word;
                        bit_cnt <= done ? '0 : bit_cnt + 6'd1;
                     end
                     if (done) begin
                        word_idx <= last_w ? '0 : word_idx + WW'(1);
                        if (room) begin
                           link.out_vld  <= 1'b1;
                           link.out_dat  <= word;
                           link.out_last <= last_w;
                        end else begin
                           ovf_pulse <= 1'b1;
                        end
                     end
                  end
               end
               ERR:     state <= p_s && n_s ? IDLE : ERR;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alink_rx_lane.sv
// tb_alink_rx_lane: directed stimulus with a scoreboard queue; a negedge monitor
// pops the expected word whenever the DUT hands one over.
module tb_alink_rx_lane;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic rx_p = 1'b1;
   logic rx_n = 1'b1;
   logic err_pulse, tout_pulse, ovf_pulse, busy;
   int   checks = 0;
   int   errors = 0;
   int   err_cnt = 0;
   int   tout_cnt = 0;
   int   ovf_cnt = 0;
   int   words = 0;
   logic [32:0] exp_q[$];
   logic [32:0] e;

   alink_rx_lane_if link();

   alink_rx_lane #(.MIN_PULSE(4), .GAP_TOUT(1024), .FRAME_WORDS(8)) dut (
      .clk(clk), .rst(rst), .en(en), .rx_p(rx_p), .rx_n(rx_n), .link(link),
      .err_pulse(err_pulse), .tout_pulse(tout_pulse), .ovf_pulse(ovf_pulse), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (err_pulse) err_cnt++;
      if (tout_pulse) tout_cnt++;
      if (ovf_pulse) ovf_cnt++;
      if (link.out_vld && link.out_rdy) begin
         words++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", link.out_dat);
         end else begin
            e = exp_q.pop_front();
            chk("word_dat", 64'(link.out_dat), 64'(e[31:0]));
            chk("word_last", 64'(link.out_last), 64'(e[32]));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      if (b) rx_p = 1'b0; else rx_n = 1'b0;
      wait_cyc(6);
      rx_p = 1'b1;
      rx_n = 1'b1;
      wait_cyc(6);
   endtask

   task automatic send_word(input logic [31:0] w, input logic lst, input bit push);
      if (push) exp_q.push_back({lst, w});
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   logic [31:0] vec [8] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_5A5A, 32'hC3C3_3C3C};

   initial begin
      int e0, w0, n;
      logic [31:0] t2w;
      link.out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vld", 64'(link.out_vld), 0);
      chk("rst_dat", 64'(link.out_dat), 0);
      chk("rst_last", 64'(link.out_last), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_events", 64'({err_pulse, tout_pulse, ovf_pulse}), 0);
      wait_cyc(1);
      rst = 1'b0;
      wait_cyc(4);

      // T1: full report, last only on word 8
      for (int i = 0; i < 8; i++) send_word(vec[i], i == 7, 1'b1);
      wait_cyc(6);
      chk("t1_words", 64'(words), 8);
      chk("t1_pending", 64'(exp_q.size()), 0);
      chk("t1_events", 64'(err_cnt + tout_cnt + ovf_cnt), 0);
      chk("t1_busy", 64'(busy), 0);

      // T2: 2-cycle glitch on rx_n after bit 10 is filtered out
      t2w = 32'hA5A5_0F0F;
      e0 = err_cnt;
      exp_q.push_back({1'b0, t2w});
      for (int i = 31; i >= 0; i--) begin
         send_bit(t2w[i]);
         if (i == 22) begin
            rx_n = 1'b0;
            wait_cyc(2);
            rx_n = 1'b1;
            wait_cyc(6);
         end
      end
      wait_cyc(6);
      chk("t2_pending", 64'(exp_q.size()), 0);
      chk("t2_err", 64'(err_cnt - e0), 0);

      // T3: coding violation after 5 bits drops partial and restarts the report
      for (int i = 0; i < 5; i++) send_bit(1'(i));
      rx_p = 1'b0;
      rx_n = 1'b0;
      wait_cyc(4);
      rx_p = 1'b1;
      rx_n = 1'b1;
      wait_cyc(6);
      chk("t3_err", 64'(err_cnt - e0), 1);
      chk("t3_busy", 64'(busy), 0);
      for (int i = 0; i < 8; i++) send_word(vec[7 - i], i == 7, 1'b1);
      wait_cyc(6);
      chk("t3_pending", 64'(exp_q.size()), 0);
      chk("t3_err_once", 64'(err_cnt - e0), 1);

      // T4: 17 bits then silence -> timeout 2 sync + 1 register + 1024 idle edges after release
      w0 = words;
      for (int i = 0; i < 16; i++) send_bit(1'b1);
      rx_n = 1'b0;
      wait_cyc(6);
      rx_n = 1'b1;
      n = 0;
      while (n < 1100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 100) chk("t4_busy_mid", 64'(busy), 1);
         if (tout_pulse) break;
      end
      chk("t4_tout_time", 64'(n), 1024 + 3);
      chk("t4_busy_after", 64'(busy), 0);
      wait_cyc(2);
      chk("t4_tout_cnt", 64'(tout_cnt), 1);
      chk("t4_no_word", 64'(words - w0), 0);

      // T5: consumer stalled, second word overflows
      link.out_rdy = 1'b0;
      send_word(32'h0BAD_F00D, 1'b0, 1'b0);
      chk("t5_vld", 64'(link.out_vld), 1);
      chk("t5_dat1", 64'(link.out_dat), 64'h0BAD_F00D);
      send_word(32'h1357_9BDF, 1'b0, 1'b0);
      chk("t5_ovf", 64'(ovf_cnt), 1);
      chk("t5_dat_hold", 64'(link.out_dat), 64'h0BAD_F00D);
      w0 = words;
      exp_q.push_back({1'b0, 32'h0BAD_F00D});
      link.out_rdy = 1'b1;
      wait_cyc(5);
      chk("t5_pop_one", 64'(words - w0), 1);
      chk("t5_vld_after", 64'(link.out_vld), 0);

      // T6: async reset mid-word clears outputs at once
      link.out_rdy = 1'b0;
      send_word(32'h2468_ACE0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) send_bit(1'b0);
      rst = 1'b1;
      #1;
      chk("t6_rst_vld", 64'(link.out_vld), 0);
      chk("t6_rst_dat", 64'(link.out_dat), 0);
      chk("t6_rst_busy", 64'(busy), 0);
      wait_cyc(3);
      rst = 1'b0;
      link.out_rdy = 1'b1;
      wait_cyc(3);
      // en=0 mid-word clears the partial and masks violations
      e0 = err_cnt;
      for (int i = 0; i < 20; i++) send_bit(1'b1);
      en = 1'b0;
      wait_cyc(2);
      chk("t6_en_busy", 64'(busy), 0);
      rx_p = 1'b0;
      rx_n = 1'b0;
      wait_cyc(4);
      rx_p = 1'b1;
      rx_n = 1'b1;
      wait_cyc(4);
      en = 1'b1;
      wait_cyc(2);
      chk("t6_en_err", 64'(err_cnt - e0), 0);
      w0 = words;
      send_word(32'h7E57_C0DE, 1'b0, 1'b1);
      wait_cyc(6);
      chk("t6_words", 64'(words - w0), 1);
      chk("t6_pending", 64'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
